sram_ctrl_param: RTL

Parametrised external-SRAM controller that turns one DATA_W-wide memory-stage access into DATA_W/16 sequential 16-bit SRAM beats. It sits between the pipeline memory stage and the board SRAM pins, with configurable base-address offset and per-beat wait states. It stalls the requester with `ready` until the whole word is written or assembled.

---
 rtl/sram_ctrl_param.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param
// Splits one DATA_W-wide memory-stage access into DATA_W/16 sequential
// 16-bit beats on an asynchronous external SRAM. Each beat is held for
// WAIT_CYCLES+1 clocks. The requester is stalled through `ready` until the
// whole word has been written or assembled.
//
// Optional feature: define SRAM_CTRL_BYTE_MASK_EN to add the byte_en port.
// Write beats then drive SRAM_LB_N/SRAM_UB_N from the latched mask. Without
// the macro both byte lanes are always enabled.
module sram_ctrl_param #(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [DATA_W-1:0]   writeData,
`ifdef SRAM_CTRL_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] byte_en,
`endif
  output logic [DATA_W-1:0]   readData,
  output logic                ready,
  inout  wire  [15:0]         SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  // Number of 16-bit beats per request and the counter widths they need.
  localparam int NBEATS = DATA_W / 16;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                op_wr_q;
  logic [SRAM_AW-1:0]  word_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                req_d;
  logic [SRAM_AW-1:0]  word_d;
  logic                beat_end_d;
  logic                access_wr_d;
  logic                capture_d;
  logic [15:0]         wlane_d;

  // Write data split into its 16-bit lanes, lane k = bits [16k+15:16k].
  logic [15:0]         wlane [NBEATS];

  genvar gi;
  generate
    for (gi = 0; gi < NBEATS; gi++) begin : g_wlane
      assign wlane[gi] = wdata_q[16*gi +: 16];
    end
  endgenerate

  // A request is any enable; write takes priority when both are high.
  assign req_d = wr_en | rd_en;

  // SRAM word of the first beat: 32-bit modulo offset from the base, halved,
  // then folded into the SRAM address space (low addresses wrap silently).
  assign word_d = SRAM_AW'((address - ADDR_BASE) >> 1);

  // The current beat ends once its hold counter reaches the programmed wait.
  assign beat_end_d = (wait_q == LAST_WAIT);

  assign access_wr_d = (state_q == S_ACCESS) && op_wr_q;
  assign capture_d   = (state_q == S_ACCESS) && !op_wr_q && beat_end_d;

`ifdef SRAM_CTRL_BYTE_MASK_EN
  logic [DATA_W/8-1:0] be_q;
  logic [1:0]          blane [NBEATS];
  logic [1:0]          blane_d;

  generate
    for (gi = 0; gi < NBEATS; gi++) begin : g_blane
      assign blane[gi] = be_q[2*gi +: 2];
    end
  endgenerate

  // Pick the two byte-enable bits belonging to the beat on the bus.
  always_comb begin
    blane_d = 2'b11;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        blane_d = blane[k];
      end
    end
  end

  // Reads and idle cycles keep both byte lanes enabled.
  assign SRAM_LB_N = access_wr_d ? !blane_d[0] : 1'b0;
  assign SRAM_UB_N = access_wr_d ? !blane_d[1] : 1'b0;
`else
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
`endif

  // Request FSM: latch the request on acceptance, step beats and wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
`ifdef SRAM_CTRL_BYTE_MASK_EN
      be_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_d) begin
            state_q <= S_ACCESS;
            beat_q  <= '0;
            wait_q  <= '0;
            op_wr_q <= wr_en;
            word_q  <= word_d;
            wdata_q <= writeData;
`ifdef SRAM_CTRL_BYTE_MASK_EN
            be_q    <= byte_en;
`endif
          end
        end
        S_ACCESS: begin
          if (beat_end_d) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= S_DONE;
            end else begin
              beat_q <= beat_q + 1'b1;
              wait_q <= '0;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          beat_q  <= '0;
          wait_q  <= '0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Select the write lane for the beat currently on the bus.
  always_comb begin
    wlane_d = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        wlane_d = wlane[k];
      end
    end
  end

  // Sample the bus into the matching read lane on the last cycle of a beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (capture_d) begin
      for (int k = 0; k < NBEATS; k++) begin
        if (beat_q == BEAT_W'(k)) begin
          rdata_q[16*k +: 16] <= SRAM_DQ;
        end
      end
    end
  end

  assign readData  = rdata_q;

  // The data bus is only driven while the write strobe is active.
  assign SRAM_WE_N = !access_wr_d;
  assign SRAM_DQ   = access_wr_d ? wlane_d : 16'hzzzz;
  assign SRAM_ADDR = (state_q == S_ACCESS) ? (word_q + SRAM_AW'(beat_q)) : '0;

  // Chip and output enables are permanently asserted.
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // Free when idle with no request pending, and on the completion cycle.
  assign ready = ((state_q == S_IDLE) && !req_d) || (state_q == S_DONE);

endmodule
